frame_inserter: RTL

- Transmit-side framer: inserts the fixed synchronisation preamble ahead of every PAYLOAD_LEN-bit payload block in the serial bit stream.
- Sits between the interleaver output and the channel.
- Produces exactly the frame structure the receive-side frame finder searches for and locks to.
- A bypass mode passes data through unframed; it mirrors the receiver's frame-finder bypass.

---
 rtl/frame_inserter_pkg.sv | 22 ++
 rtl/frame_inserter_if.sv | 30 +++
 rtl/frame_inserter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/frame_inserter_pkg.sv
// Shared framing definitions for the transmit framer and the receive frame finder.
// Both sides take their preamble and block size from here so the frame format
// cannot drift between transmitter and receiver.
package frame_inserter_pkg;

    localparam int          FI_PREAMBLE_LEN = 16;
    localparam logic [15:0] FI_PREAMBLE_VAL = 16'hF628;
    localparam int          FI_PAYLOAD_LEN  = 240;  // ROW_NUMBER * COL_NUMBER of the deinterleaver

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_BYPASS   = 2'd3
    } fi_state_e;

    // Preamble bit k of a len-bit pattern, sent MSB first.
    function automatic logic preamble_bit(input logic [63:0] pat, input int len, input int k);
        return pat[6'(len - 1 - k)];
    endfunction

endpackage

// File: rtl/frame_inserter_if.sv
// Serial bit-stream bundle between the interleaver, the framer and the channel.
//
// Handshake: on the input side a bit transfers on a rising clock edge where
// DATA_IN_VALID and DATA_IN_READY are both 1. READY never depends on VALID in the
// same cycle, and the source may hold or withdraw VALID freely while READY is low.
// The output side has no back-pressure: DATA_OUT is a valid channel bit in every
// cycle where DATA_OUT_VALID is 1.
interface frame_inserter_if;

    logic FRAMER_ON;
    logic DATA_IN;
    logic DATA_IN_VALID;
    logic DATA_IN_READY;
    logic DATA_OUT;
    logic DATA_OUT_VALID;
    logic FRAME_START;

    // Upstream / environment side.
    modport master (
        output FRAMER_ON, DATA_IN, DATA_IN_VALID,
        input  DATA_IN_READY, DATA_OUT, DATA_OUT_VALID, FRAME_START
    );

    // The framer itself.
    modport slave (
        input  FRAMER_ON, DATA_IN, DATA_IN_VALID,
        output DATA_IN_READY, DATA_OUT, DATA_OUT_VALID, FRAME_START
    );

endinterface

// File: rtl/frame_inserter.sv
// Transmit-side framer: puts the sync preamble ahead of every PAYLOAD_LEN-bit
// payload block, or passes the stream through untouched in bypass mode.
// All outputs are registered; READY is decoded from the state register only.
module frame_inserter
    import frame_inserter_pkg::*;
#(
    parameter int                      PREAMBLE_LEN = FI_PREAMBLE_LEN,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_VAL = FI_PREAMBLE_VAL,
    parameter int                      PAYLOAD_LEN  = FI_PAYLOAD_LEN
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    frame_inserter_if.slave         bus,
    output fi_state_e               dbg_state
);

    localparam int PRE_W = $clog2(PREAMBLE_LEN);
    localparam int PAY_W = $clog2(PAYLOAD_LEN + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);
    localparam logic [PAY_W-1:0] PAY_LAST = PAY_W'(PAYLOAD_LEN - 1);

    fi_state_e         state_q, state_d;
    logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [PAY_W-1:0]  pay_cnt_q, pay_cnt_d;
    logic              data_out_q, data_out_d;
    logic              data_out_valid_q, data_out_valid_d;
    logic              frame_start_q, frame_start_d;

    logic in_ready;
    logic accept;
    logic pre_last;
    logic pay_last;

    // Handshake decode: READY comes from the state alone, never from VALID.
    always_comb begin
        in_ready = (state_q == ST_PAYLOAD) || (state_q == ST_BYPASS);
        accept   = in_ready && bus.DATA_IN_VALID;
        pre_last = (pre_cnt_q == PRE_LAST);
        pay_last = (pay_cnt_q == PAY_LAST);
    end

    // State register; reset mid-frame simply abandons the frame.
    always_ff @(posedge CLK) begin
        if (!RESET_N) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; FRAMER_ON only matters in IDLE, BYPASS and at the end of a payload block.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.FRAMER_ON)         state_d = ST_BYPASS;
                else if (bus.DATA_IN_VALID) state_d = ST_PREAMBLE;  // pending bit stays in place
            end
            ST_PREAMBLE: begin
                if (pre_last) state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (accept && pay_last) state_d = bus.FRAMER_ON ? ST_PREAMBLE : ST_BYPASS;
            end
            ST_BYPASS: begin
                if (bus.FRAMER_ON) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Preamble and payload counters; each returns to zero when its state is left.
    always_comb begin
        pre_cnt_d = '0;
        if (state_q == ST_PREAMBLE && !pre_last) pre_cnt_d = pre_cnt_q + 1'b1;

        pay_cnt_d = '0;
        if (state_q == ST_PAYLOAD) begin
            pay_cnt_d = pay_cnt_q;
            if (accept) pay_cnt_d = pay_last ? '0 : pay_cnt_q + 1'b1;
        end
    end

    // Output register inputs: preamble bits, or the accepted bit one cycle later.
    always_comb begin
        data_out_d       = data_out_q;  // hold last value through gaps
        data_out_valid_d = 1'b0;
        frame_start_d    = 1'b0;
        case (state_q)
            ST_PREAMBLE: begin
                data_out_d       = preamble_bit(64'(PREAMBLE_VAL), PREAMBLE_LEN, int'(pre_cnt_q));
                data_out_valid_d = 1'b1;
                frame_start_d    = (pre_cnt_q == '0);
            end
            ST_PAYLOAD, ST_BYPASS: begin
                if (accept) begin
                    data_out_d       = bus.DATA_IN;
                    data_out_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Counter and output registers.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            pre_cnt_q        <= '0;
            pay_cnt_q        <= '0;
            data_out_q       <= 1'b0;
            data_out_valid_q <= 1'b0;
            frame_start_q    <= 1'b0;
        end else begin
            pre_cnt_q        <= pre_cnt_d;
            pay_cnt_q        <= pay_cnt_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            frame_start_q    <= frame_start_d;
        end
    end

    assign bus.DATA_IN_READY  = in_ready;
    assign bus.DATA_OUT       = data_out_q;
    assign bus.DATA_OUT_VALID = data_out_valid_q;
    assign bus.FRAME_START    = frame_start_q;
    assign dbg_state          = state_q;

endmodule
